// File: rtl/simd_array_pkg.sv
// Shared opcode encoding and default geometry for the SIMD array pipeline.
package simd_array_pkg;
  localparam int DEF_UNIT_SIZE = 32;
  localparam int DEF_LANES     = 5;
  localparam int DEF_MAT_DIM   = 3;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MATVEC = 2'd2,
    OP_MAC    = 2'd3
  } op_e;
endpackage

// File: rtl/simd_matvec_core.sv
// Combinational Toeplitz matrix-vector product; all arithmetic wraps at UNIT_SIZE.
module simd_matvec_core #(
  parameter int UNIT_SIZE = 32,
  parameter int LANES     = 5,
  parameter int MAT_DIM   = 3
) (
  input  logic [UNIT_SIZE*LANES-1:0] mat,
  input  logic [UNIT_SIZE*LANES-1:0] vec_src,
  output logic [UNIT_SIZE*LANES-1:0] y
);
  typedef logic [LANES-1:0][UNIT_SIZE-1:0] word_t;

  // Packed index = field position from the LSB, so lane k lives at index LANES-1-k.
  word_t m_f, v_f, y_f;
  logic  unused;

  assign m_f    = mat;
  assign v_f    = vec_src;
  assign y      = y_f;
  assign unused = ^{m_f, v_f};

  always_comb begin
    y_f = '0;
    for (int r = 0; r < MAT_DIM; r++)
      for (int j = 0; j < MAT_DIM; j++)
        y_f[LANES-1-r] = y_f[LANES-1-r] + v_f[LANES-1-j] * m_f[MAT_DIM-1-j+r];
  end
endmodule

// File: rtl/simd_array_pipe.sv
// Two-stage SIMD pipe: lane add/sub, Toeplitz matvec and multi-beat mac with
// valid/ready on both sides.
module simd_array_pipe
  import simd_array_pkg::*;
#(
  parameter int UNIT_SIZE = DEF_UNIT_SIZE,
  parameter int LANES     = DEF_LANES,
  parameter int MAT_DIM   = DEF_MAT_DIM
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [1:0]                 i_opcode,
  input  logic                       i_last,
  input  logic [UNIT_SIZE*LANES-1:0] i_in1,
  input  logic [UNIT_SIZE*LANES-1:0] i_in2,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [UNIT_SIZE*LANES-1:0] o_res,
  output logic                       o_ovf
);
  localparam int W = UNIT_SIZE * LANES;

  if (2*MAT_DIM-1 > LANES) begin : g_bad_cfg
    $error("simd_array_pipe: 2*MAT_DIM-1 exceeds LANES");
  end

  typedef logic [LANES-1:0][UNIT_SIZE-1:0] word_t;

  typedef struct packed {
    op_e   op;
    logic  last;
    word_t res;
    logic  ovf;
  } s1_t;

  word_t            a, b, y, lane_res, acc, acc_sum, res2;
  logic [LANES-1:0] lane_ovf;
  logic [W-1:0]     y_flat;
  logic [2:1]       vld_pipe;
  logic             s1_free, s2_free, accept, ovf2;
  s1_t              s1, s1_next;

  assign a = i_in1;
  assign b = i_in2;
  assign y = y_flat;

  simd_matvec_core #(
    .UNIT_SIZE(UNIT_SIZE),
    .LANES    (LANES),
    .MAT_DIM  (MAT_DIM)
  ) u_core (
    .mat    (i_in1),
    .vec_src(i_in2),
    .y      (y_flat)
  );

  // Signed overflow: add flips when like-signed operands give an unlike sign;
  // sub flips when operand signs differ and the result sign leaves a's sign.
  for (genvar f = 0; f < LANES; f++) begin : g_lane
    logic sa, sb, sr;
    assign lane_res[f] = (i_opcode == OP_SUB) ? a[f] - b[f] : a[f] + b[f];
    assign sa          = a[f][UNIT_SIZE-1];
    assign sb          = b[f][UNIT_SIZE-1];
    assign sr          = lane_res[f][UNIT_SIZE-1];
    assign lane_ovf[f] = (i_opcode == OP_SUB) ? (sa != sb) && (sr != sa)
                                              : (sa == sb) && (sr != sa);
    assign acc_sum[f]  = acc[f] + s1.res[f];
  end

  always_comb begin
    s1_next      = '0;
    s1_next.op   = op_e'(i_opcode);
    s1_next.last = i_last;
    s1_next.res  = i_opcode[1] ? y : lane_res;
    s1_next.ovf  = !i_opcode[1] && (|lane_ovf);
  end

  assign s2_free = !vld_pipe[2] || i_ready;
  assign s1_free = !vld_pipe[1] || s2_free;
  assign o_ready = !i_rst && s1_free;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      res2     <= '0;
      ovf2     <= 1'b0;
      acc      <= '0;
    end else begin
      if (s1_free) begin
        vld_pipe[1] <= accept;
        if (accept) s1 <= s1_next;
      end
      // Non-final mac beats fold into acc and vanish from the output stream.
      if (s2_free) begin
        vld_pipe[2] <= vld_pipe[1] && !(s1.op == OP_MAC && !s1.last);
        if (vld_pipe[1]) begin
          if (s1.op == OP_MAC) begin
            if (s1.last) begin
              res2 <= acc_sum;
              ovf2 <= 1'b0;
              acc  <= '0;
            end else begin
              acc  <= acc_sum;
            end
          end else begin
            res2 <= s1.res;
            ovf2 <= s1.ovf;
          end
        end
      end
    end
  end

  assign o_valid = vld_pipe[2];
  assign o_res   = res2;
  assign o_ovf   = ovf2;
endmodule
